nes_button_events: RTL and testbench
====================================

# nes_button_events

Downstream consumer of the NES controller reader's 8-bit parallel button word. Debounces each button across poll frames, detects press/release edges, serialises simultaneous edges into single events, and buffers them in a small first-word-fall-through FIFO. Game and menu logic read one event per handshake instead of polling raw levels.

## Interface
Parameters:
- DEBOUNCE_FRAMES, 2: consecutive frames a changed level must persist before it is accepted; legal range 1..15.
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..64.

Ports:
- clk_10MHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_valid  input  1  one-cycle strobe: `buttons` holds a completed poll.
- buttons  input  8  raw levels, 1 = pressed. Bit 7..0 = A, B, Select, Start, Up, Down, Left, Right.
- event_ready  input  1  consumer accepts the head event this cycle.
- event_valid  output  1  FIFO not empty.
- event_code  output  4  head event. Bit 3 = 1 press / 0 release; bits 2:0 = button index.
- held  output  8  debounced button state.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries currently stored.
- overflow  output  1  sticky: a button edge was lost.

## Operation
- Reset values: held=0, all debounce counters 0, pending=0, FIFO empty, event_valid=0, event_code=0, fifo_count=0, overflow=0.
- Debounce is per bit i and is evaluated only on cycles where frame_valid=1.
  - If buttons[i]==held[i], cnt[i] clears to 0.
  - Otherwise cnt[i] increments.
  - When the increment reaches DEBOUNCE_FRAMES, held[i] toggles, cnt[i] clears, and pending[i] sets.
  - With DEBOUNCE_FRAMES=1, a change is accepted on its first frame.
- Lost-edge rule: if held[i] toggles while pending[i] is already 1, overflow sets (sticky until reset). pending[i] stays 1. The later event reports held[i] at push time, so one press/release pair is lost.
- Scanner runs every cycle.
  - If pending≠0 and fifo_count<FIFO_DEPTH, select the highest set index i.
  - Push {held[i], i[2:0]} and clear pending[i] in the same cycle.
  - At most one push per cycle.
  - While the FIFO is full, the scanner stalls. pending is retained, so no edge is lost to a full FIFO.
- Same-cycle pending set/clear: if a scanner clear and a new toggle on the same bit coincide, the set wins and no overflow is flagged.
- FIFO is first-word-fall-through. event_code is valid whenever event_valid=1, and a pop occurs when event_valid && event_ready.
  - The full check uses fifo_count before the pop. When full, a simultaneous pop and push attempt leaves the push waiting one cycle.
  - Simultaneous push and pop when not full: fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - event_ready while empty is ignored.

## Timing
- frame_valid at cycle t: held and pending update at t+1.
- Scanner pushes during t+1, so event_valid rises at t+2 for the first event.
- k simultaneous accepted edges reach the FIFO on consecutive cycles, highest index first. The last arrives at t+1+k if the FIFO is not full.
- Pop at cycle p: the next entry appears on event_code at p+1, and fifo_count decrements at p+1.
- Reset asserted mid-scan or mid-frame clears everything asynchronously; operation resumes on the first clock edge after deassertion.
- frame_valid on consecutive cycles is legal; each cycle counts as one frame.

## Structure
- Shared package nes_pkg:
  - button index constants BTN_A=7 … BTN_RIGHT=0
  - NES_BUTTONS=8
  - EVT_PRESS=1'b1
  - event_t packed struct {logic press; logic [2:0] idx;}
  - The package is shared with the controller reader and game logic.
- One sub-module, nes_event_fifo: synchronous FWFT FIFO parameterised by width and depth, with count output.
- Debounce counters, pending register and priority scanner stay in the top level.

## Test plan
- Reset, then 2 frames with buttons=8'h80 → held=8'h80 one cycle after the second frame; event_code=4'hF, event_valid=1 two cycles after the second frame.
- Glitch: buttons=8'h01 for one frame, then 8'h00 → no event, held=0, cnt cleared.
- 8'hFF held for 2 frames, event_ready=0, FIFO_DEPTH=8 → 8 events, codes F,E,D,C,B,A,9,8 in order; fifo_count=8, overflow=0.
- With the FIFO full, 2 frames of 8'h00 plus 8 further pops → 8 release events 7,6,…,0 follow the press events; no loss, overflow=0.
- Fill the FIFO; press then release A (4 frames) with no pops → overflow=1 and stays 1 until reset.
- Assert reset during a scan of 8'hFF edges → all outputs 0 immediately; no events after deassertion until a new debounced change.

Source files
------------

// File: rtl/nes_pkg.sv
// Types and constants shared by the NES controller reader, button event logic and game logic.
// Button indices follow the controller's shift-out order, with A in the top bit.
package nes_pkg;

   localparam int NES_BUTTONS = 8;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   localparam logic EVT_PRESS = 1'b1;

   typedef struct packed {
      logic       press;
      logic [2:0] idx;
   } event_t;

   // Index of the most significant set bit; 0 when none is set.
   function automatic logic [2:0] highest_index(input logic [NES_BUTTONS-1:0] v);
      highest_index = 3'd0;
      for (int k = 0; k < NES_BUTTONS; k++) begin
         if (v[k]) highest_index = 3'(k);
      end
   endfunction

endpackage

// File: rtl/nes_event_fifo.sv
// First-word-fall-through FIFO with occupancy count. A push into a full FIFO is dropped,
// and the full test uses the count before any same-cycle pop.
module nes_event_fifo #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count < CW'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   assign o_valid = (r_count != '0);
   assign o_count = r_count;
   // Head is shown combinationally so it is on the output as soon as it is stored.
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/nes_button_events.sv
// Debounces the 8 NES buttons per poll frame and queues press/release events,
// serialised highest index first, through a small FWFT FIFO.
module nes_button_events
   import nes_pkg::*;
#(
   parameter  int DEBOUNCE_FRAMES = 2,
   parameter  int FIFO_DEPTH      = 8,
   localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clk_10MHz,
   input  logic                   reset,
   input  logic                   frame_valid,
   input  logic [NES_BUTTONS-1:0] buttons,
   input  logic                   event_ready,
   output logic                   event_valid,
   output logic [3:0]             event_code,
   output logic [NES_BUTTONS-1:0] held,
   output logic [CW-1:0]          fifo_count,
   output logic                   overflow
);

   logic [3:0]             r_cnt [NES_BUTTONS];
   logic [3:0]             w_cnt_next [NES_BUTTONS];
   logic [NES_BUTTONS-1:0] r_held;
   logic [NES_BUTTONS-1:0] r_pending;
   logic                   r_overflow;
   logic [NES_BUTTONS-1:0] w_toggle;
   logic [NES_BUTTONS-1:0] w_clear;
   logic [2:0]             w_idx;
   logic                   w_push;
   event_t                 w_evt;

   genvar gi;
   generate
      for (gi = 0; gi < NES_BUTTONS; gi++) begin : g_debounce
         assign w_toggle[gi] = frame_valid && (buttons[gi] != r_held[gi]) &&
                               (r_cnt[gi] == 4'(DEBOUNCE_FRAMES - 1));
         assign w_cnt_next[gi] = !frame_valid                                  ? r_cnt[gi] :
                                 ((buttons[gi] == r_held[gi]) || w_toggle[gi]) ? 4'd0      :
                                                                                 r_cnt[gi] + 4'd1;
      end
   endgenerate

   // The scanner holds off while the FIFO is full, so edges wait in pending instead of being dropped.
   assign w_push    = (r_pending != '0) && (fifo_count < CW'(FIFO_DEPTH));
   assign w_idx     = highest_index(r_pending);
   assign w_clear   = w_push ? (NES_BUTTONS'(1) << w_idx) : '0;
   assign w_evt.press = (r_held[w_idx] == EVT_PRESS);
   assign w_evt.idx   = w_idx;

   always_ff @(posedge clk_10MHz or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NES_BUTTONS; k++) r_cnt[k] <= 4'd0;
         r_held     <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         for (int k = 0; k < NES_BUTTONS; k++) r_cnt[k] <= w_cnt_next[k];
         r_held    <= r_held ^ w_toggle;
         // A new toggle beats a same-cycle scanner clear; only a still-unserved edge counts as lost.
         r_pending <= (r_pending & ~w_clear) | w_toggle;
         if ((w_toggle & r_pending & ~w_clear) != '0) r_overflow <= 1'b1;
      end
   end

   nes_event_fifo #(
      .WIDTH ($bits(event_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_10MHz),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (w_evt),
      .i_pop   (event_ready),
      .o_data  (event_code),
      .o_valid (event_valid),
      .o_count (fifo_count)
   );

   assign held     = r_held;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_nes_button_events.sv
// Self-checking bench for nes_button_events: vector table, corner-case sequences and
// randomized frames scored against an event-level reference model.
module tb_nes_button_events;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_valid;
   logic [7:0] buttons;
   logic       event_ready;
   logic       event_valid;
   logic [3:0] event_code;
   logic [7:0] held;
   logic [3:0] fifo_count;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   nes_button_events #(.DEBOUNCE_FRAMES(2), .FIFO_DEPTH(8)) dut (
      .clk_10MHz   (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .buttons     (buttons),
      .event_ready (event_ready),
      .event_valid (event_valid),
      .event_code  (event_code),
      .held        (held),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   always #50 clk = ~clk;

   typedef struct {
      logic       fv;
      logic [7:0] btn;
      logic       rdy;
      logic [7:0] e_held;
      logic       e_valid;
      logic [3:0] e_code;
      logic [3:0] e_count;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      frame_valid = 1'b0;
      event_ready = 1'b0;
      buttons = 8'h00;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic frame(input logic [7:0] b);
      frame_valid = 1'b1;
      buttons = b;
      step();
      frame_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reference model state for the randomized phase.
   logic [3:0] expq[$];
   logic [7:0] hm;
   int         cm[8];

   task automatic model_frame(input logic [7:0] b);
      logic [7:0] tog;
      tog = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i] == hm[i]) cm[i] = 0;
         else begin
            cm[i] = cm[i] + 1;
            if (cm[i] == 2) begin
               cm[i] = 0;
               tog[i] = 1'b1;
            end
         end
      end
      hm = hm ^ tog;
      for (int i = 7; i >= 0; i--)
         if (tog[i]) expq.push_back({hm[i], 3'(i)});
   endtask

   task automatic rcyc(input bit force_ready);
      event_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (event_valid && event_ready) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand_unexpected_event: got %0h expected none", event_code);
         end else begin
            chk("rand_event", event_code, expq.pop_front());
         end
      end
      step();
   endtask

   initial begin
      logic [3:0] expA[16];
      logic [3:0] gotB[16];
      int got;
      logic [7:0] b;

      reset = 1'b1;
      frame_valid = 1'b0;
      event_ready = 1'b0;
      buttons = 8'h00;
      #1;
      chk("async_reset_held", held, 0);
      do_reset();
      chk("rst_held", held, 0);
      chk("rst_valid", event_valid, 0);
      chk("rst_code", event_code, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);

      // fv, btn, rdy -> held, valid, code, count (observed after the edge)
      vt[0]  = '{1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 4'h0, 4'd0};
      vt[1]  = '{1'b1, 8'h80, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[2]  = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b1, 4'hF, 4'd1};
      vt[3]  = '{1'b0, 8'h80, 1'b1, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[4]  = '{1'b1, 8'h81, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[5]  = '{1'b1, 8'h80, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[6]  = '{1'b1, 8'h81, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[7]  = '{1'b1, 8'h80, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[8]  = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[9]  = '{1'b1, 8'h00, 1'b0, 8'h80, 1'b0, 4'h0, 4'd0};
      vt[10] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 4'd0};
      vt[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 4'h7, 4'd1};
      vt[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4'h0, 4'd0};
      for (int i = 0; i < 13; i++) begin
         frame_valid = vt[i].fv;
         buttons = vt[i].btn;
         event_ready = vt[i].rdy;
         step();
         chk($sformatf("vec%0d_held", i), held, vt[i].e_held);
         chk($sformatf("vec%0d_valid", i), event_valid, vt[i].e_valid);
         chk($sformatf("vec%0d_code", i), event_code, vt[i].e_code);
         chk($sformatf("vec%0d_count", i), fifo_count, vt[i].e_count);
      end
      frame_valid = 1'b0;
      event_ready = 1'b0;

      // All buttons pressed, FIFO fills, then all released while full.
      do_reset();
      frame(8'hFF);
      frame(8'hFF);
      chk("fill_held", held, 8'hFF);
      idle(10);
      chk("fill_count", fifo_count, 8);
      chk("fill_overflow", overflow, 0);
      chk("fill_head", event_code, 4'hF);
      frame(8'h00);
      frame(8'h00);
      idle(2);
      chk("full_release_held", held, 8'h00);
      chk("full_release_count", fifo_count, 8);
      for (int k = 0; k < 8; k++) expA[k] = {1'b1, 3'(7 - k)};
      for (int k = 0; k < 8; k++) expA[8 + k] = {1'b0, 3'(7 - k)};
      got = 0;
      for (int c = 0; c < 60 && got < 16; c++) begin
         event_ready = 1'b1;
         if (event_valid) begin
            chk($sformatf("drainA_%0d", got), event_code, expA[got]);
            got++;
         end
         step();
      end
      event_ready = 1'b0;
      chk("drainA_total", got, 16);
      chk("drainA_count", fifo_count, 0);
      chk("drainA_valid", event_valid, 0);
      chk("drainA_overflow", overflow, 0);

      // Lost edge: A released and re-pressed while its release is still waiting.
      do_reset();
      frame(8'hFF);
      frame(8'hFF);
      idle(10);
      chk("ovf_prefill_count", fifo_count, 8);
      frame(8'h7F);
      frame(8'h7F);
      chk("ovf_release_held", held, 8'h7F);
      chk("ovf_after_first", overflow, 0);
      frame(8'hFF);
      frame(8'hFF);
      chk("ovf_set", overflow, 1);
      got = 0;
      for (int c = 0; c < 40; c++) begin
         event_ready = 1'b1;
         if (event_valid && got < 16) begin
            gotB[got] = event_code;
            got++;
         end
         step();
      end
      event_ready = 1'b0;
      chk("ovf_events", got, 9);
      chk("ovf_ninth", gotB[8], 4'hF);
      chk("ovf_sticky", overflow, 1);
      reset = 1'b1;
      #1;
      chk("ovf_cleared_by_reset", overflow, 0);
      step();
      reset = 1'b0;

      // Reset in the middle of a scan.
      do_reset();
      frame(8'hFF);
      frame(8'hFF);
      step();
      chk("midscan_count_before", fifo_count, 1);
      #10;
      reset = 1'b1;
      #1;
      chk("midscan_held", held, 0);
      chk("midscan_valid", event_valid, 0);
      chk("midscan_code", event_code, 0);
      chk("midscan_count", fifo_count, 0);
      chk("midscan_overflow", overflow, 0);
      step();
      reset = 1'b0;
      idle(20);
      chk("postrst_valid", event_valid, 0);
      chk("postrst_count", fifo_count, 0);
      chk("postrst_held", held, 0);

      // Randomized frames against the reference model.
      do_reset();
      hm = 8'h00;
      for (int i = 0; i < 8; i++) cm[i] = 0;
      expq.delete();
      b = 8'h00;
      for (int f = 0; f < 80; f++) begin
         int gap;
         gap = $urandom_range(12, 20);
         for (int c = 0; c < gap; c++) rcyc(1'b0);
         if ($urandom_range(0, 2) == 0) b = b ^ 8'($urandom_range(0, 255));
         model_frame(b);
         frame_valid = 1'b1;
         buttons = b;
         rcyc(1'b0);
         frame_valid = 1'b0;
         chk($sformatf("rand_held_f%0d", f), held, hm);
      end
      for (int c = 0; c < 40; c++) rcyc(1'b1);
      event_ready = 1'b0;
      chk("rand_queue_empty", expq.size(), 0);
      chk("rand_count_end", fifo_count, 0);
      chk("rand_overflow", overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
